// File: rtl/zero_scan_counter_pkg.sv
// -----------------------------------------------------------------------------
// zero_scan_pkg
// Shared types and helpers for the zero-run counter:
//   state_e     - FSM state enumeration {IDLE, SCAN, DONE}
//   MODE_TRAIL  - mode value for counting trailing zeros (from bit 0 upward)
//   MODE_LEAD   - mode value for counting leading zeros (from the MSB downward)
//   cnt_width() - width needed to hold a count of 0..w inclusive
// -----------------------------------------------------------------------------
package zero_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_TRAIL = 1'b0;
    localparam logic MODE_LEAD  = 1'b1;

    // A count of w zeros must itself be representable, hence w+1 values.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/zero_scan_counter_if.sv
// -----------------------------------------------------------------------------
// zero_scan_counter_if
// Request/result bundle of the zero-run counter.
//   start     - request, only honoured while the counter is idle
//   data_in   - WIDTH-bit operand, captured with an accepted start
//   mode      - MODE_TRAIL / MODE_LEAD, captured with data_in
//   busy      - counter is scanning or presenting its result
//   done      - one-cycle pulse when a new result is visible
//   count_out - last zero count (0..WIDTH), held until the next result
//   all_zero  - last operand had no set bit, held with count_out
// master: the requester; slave: the counter.
// -----------------------------------------------------------------------------
interface zero_scan_counter_if #(
    parameter int WIDTH = 8
);
    import zero_scan_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             mode;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count_out;
    logic             all_zero;

    modport master (
        output start, data_in, mode,
        input  busy, done, count_out, all_zero
    );

    modport slave (
        input  start, data_in, mode,
        output busy, done, count_out, all_zero
    );

endinterface

// File: rtl/zero_scan_counter_enc.sv
// -----------------------------------------------------------------------------
// zero_chunk_enc
// Combinational lowest-set-bit encoder for one STEP-bit chunk.
//   chunk   - bits under examination, bit 0 is scanned first
//   any_one - at least one bit of chunk is set
//   pos     - index of the lowest set bit ($clog2(STEP) bits, one constant-0
//             bit when STEP is 1); 0 when no bit is set
// -----------------------------------------------------------------------------
module zero_chunk_enc #(
    parameter  int STEP = 1,
    localparam int PW   = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [STEP-1:0] chunk,
    output logic            any_one,
    output logic [PW-1:0]   pos
);

    always_comb begin
        any_one = |chunk;
        pos     = '0;
        // Walk from the top down so the lowest set bit is the last writer.
        for (int i = STEP - 1; i >= 0; i--) begin
            if (chunk[i]) begin
                pos = PW'(i);
            end
        end
    end

endmodule

// File: rtl/zero_scan_counter.sv
// -----------------------------------------------------------------------------
// zero_scan_counter
// Handshaked trailing/leading zero counter that scans STEP bits per clock.
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset; aborts a scan without a done pulse
//   bus   - zero_scan_counter_if.slave (start/data_in/mode in,
//           busy/done/count_out/all_zero out)
// Leading-zero requests are bit-reversed on capture so the datapath only ever
// scans LSB-first. The running count stays internal; count_out/all_zero only
// update on the SCAN->DONE transition.
// -----------------------------------------------------------------------------
module zero_scan_counter
    import zero_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    zero_scan_counter_if.slave bus
);

    localparam int CW  = cnt_width(WIDTH);
    localparam int NCH = WIDTH / STEP;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_SCAN = 2'(SCAN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [CW-1:0]    run_cnt_q,  run_cnt_d;
    logic [IW-1:0]    idx_q,      idx_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             all_zero_q, all_zero_d;

    logic [WIDTH-1:0] data_rev;
    logic             any_one;
    logic [PW-1:0]    pos;
    logic             last_chunk;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign data_rev[gi] = bus.data_in[WIDTH-1-gi];
    end

    zero_chunk_enc #(
        .STEP (STEP)
    ) u_enc (
        .chunk   (shift_q[STEP-1:0]),
        .any_one (any_one),
        .pos     (pos)
    );

    assign last_chunk = (idx_q == IW'(NCH - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        run_cnt_d  = run_cnt_q;
        idx_d      = idx_q;
        count_d    = count_q;
        all_zero_d = all_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_SCAN;
                    shift_d   = (bus.mode == MODE_LEAD) ? data_rev : bus.data_in;
                    run_cnt_d = '0;
                    idx_d     = '0;
                end
            end
            S_SCAN: begin
                if (any_one) begin
                    count_d    = run_cnt_q + CW'(pos);
                    all_zero_d = 1'b0;
                    state_d    = S_DONE;
                end else if (last_chunk) begin
                    count_d    = CW'(WIDTH);
                    all_zero_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + CW'(STEP);
                    shift_d   = shift_q >> STEP;
                    idx_d     = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            run_cnt_q  <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            all_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            run_cnt_q  <= run_cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            all_zero_q <= all_zero_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.count_out = count_q;
    assign bus.all_zero  = all_zero_q;

endmodule

// File: tb/tb_zero_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_zero_scan_counter
// Three counter instances (8/1, 8/2, 16/4) driven from one initial block.
// Expected counts come from a bit-walking reference function and expected
// latencies from the cycle formula; results are checked per transaction.
// -----------------------------------------------------------------------------
module tb_zero_scan_counter;

    localparam int W_TAB [3] = '{8, 8, 16};
    localparam int S_TAB [3] = '{1, 2, 4};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    zero_scan_counter_if #(.WIDTH(8))  if0 ();
    zero_scan_counter_if #(.WIDTH(8))  if1 ();
    zero_scan_counter_if #(.WIDTH(16)) if2 ();

    zero_scan_counter #(.WIDTH(8),  .STEP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    zero_scan_counter #(.WIDTH(8),  .STEP(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    zero_scan_counter #(.WIDTH(16), .STEP(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cur      = 0;
    int prev_cnt [3];
    bit prev_az  [3];

    logic       obs_busy, obs_done, obs_az;
    logic [4:0] obs_cnt;

    always_comb begin
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_az   = 1'b0;
        obs_cnt  = '0;
        case (cur)
            0: begin obs_busy = if0.busy; obs_done = if0.done; obs_az = if0.all_zero; obs_cnt = 5'(if0.count_out); end
            1: begin obs_busy = if1.busy; obs_done = if1.done; obs_az = if1.all_zero; obs_cnt = 5'(if1.count_out); end
            default: begin obs_busy = if2.busy; obs_done = if2.done; obs_az = if2.all_zero; obs_cnt = 5'(if2.count_out); end
        endcase
    end

    // Reference: walk the operand bit by bit in scan order.
    function automatic int ref_zeros(input logic [15:0] v, input int w, input bit m);
        for (int i = 0; i < w; i++) begin
            if (v[m ? (w - 1 - i) : i]) return i;
        end
        return w;
    endfunction

    function automatic int ref_done_cycle(input int k, input int w, input int s);
        int scan;
        scan = k / s + 1;
        if (scan > w / s) scan = w / s;
        return scan + 1;
    endfunction

    task automatic drive(input int d, input bit st, input logic [15:0] data, input bit m);
        case (d)
            0: begin if0.start = st; if0.data_in = data[7:0]; if0.mode = m; end
            1: begin if1.start = st; if1.data_in = data[7:0]; if1.mode = m; end
            default: begin if2.start = st; if2.data_in = data; if2.mode = m; end
        endcase
    endtask

    // Assumes a negedge with DUT d idle; returns at the negedge of the
    // first IDLE cycle after DONE, where a new start may be applied.
    task automatic do_scan(input int d, input logic [15:0] data, input bit m,
                           input int exp_k, input int exp_dc, input bit pulse);
        int  c;
        bit  seen;
        seen = 1'b0;
        cur  = d;
        drive(d, 1'b1, data, m);
        for (c = 1; c <= exp_dc + 3; c++) begin
            @(negedge clk);
            if (obs_done) begin
                seen = 1'b1;
                break;
            end
            tot_cnt++;
            if (obs_busy !== 1'b1 || obs_cnt !== 5'(prev_cnt[d]) || obs_az !== prev_az[d]) begin
                $display("FAIL scan_hold dut%0d cyc%0d: busy=%b cnt=%0d az=%b, required busy=1 cnt=%0d az=%b",
                         d, c, obs_busy, obs_cnt, obs_az, prev_cnt[d], prev_az[d]);
            end else begin
                pass_cnt++;
            end
            if (c == 1) drive(d, 1'b0, 16'($urandom), ~m);
            if (pulse && c == 2) drive(d, 1'b1, 16'($urandom), m);
            if (pulse && c == 3) drive(d, 1'b0, 16'($urandom), m);
        end
        drive(d, 1'b0, 16'($urandom), m);
        tot_cnt++;
        if (!seen) begin
            $display("FAIL done_timeout dut%0d data=%h: no done within %0d cycles, required at cycle %0d",
                     d, data, exp_dc + 3, exp_dc);
            return;
        end
        if (c !== exp_dc) $display("FAIL latency dut%0d data=%h mode=%0d: done at cycle %0d, required %0d", d, data, m, c, exp_dc);
        else pass_cnt++;
        tot_cnt++;
        if (obs_cnt !== 5'(exp_k) || obs_busy !== 1'b1)
            $display("FAIL count dut%0d data=%h mode=%0d: cnt=%0d busy=%b, required cnt=%0d busy=1", d, data, m, obs_cnt, obs_busy, exp_k);
        else pass_cnt++;
        tot_cnt++;
        if (obs_az !== (exp_k == W_TAB[d]))
            $display("FAIL all_zero dut%0d data=%h: az=%b, required %b", d, data, obs_az, exp_k == W_TAB[d]);
        else pass_cnt++;
        $display("txn dut%0d data=%h mode=%0d count=%0d az=%b done_cycle=%0d", d, data, m, obs_cnt, obs_az, c);
        prev_cnt[d] = exp_k;
        prev_az[d]  = (exp_k == W_TAB[d]);
        @(negedge clk);
        tot_cnt++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0)
            $display("FAIL return_idle dut%0d: busy=%b done=%b, required 0/0", d, obs_busy, obs_done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b1, 16'hFFFF, 1'b0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            tot_cnt++;
            if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_cnt !== 5'd0 || obs_az !== 1'b0)
                $display("FAIL reset dut%0d: busy=%b done=%b cnt=%0d az=%b, required all 0", d, obs_busy, obs_done, obs_cnt, obs_az);
            else pass_cnt++;
            drive(d, 1'b0, 16'h0, 1'b0);
            prev_cnt[d] = 0;
            prev_az[d]  = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_scan(0, 16'h0028, 1'b0, 3, 5, 1'b0);
        do_scan(0, 16'h0028, 1'b1, 2, 4, 1'b0);
        do_scan(0, 16'h0000, 1'b0, 8, 9, 1'b0);
        do_scan(0, 16'h0001, 1'b0, 0, 2, 1'b0);
        do_scan(1, 16'h0028, 1'b0, 3, 3, 1'b0);
        do_scan(1, 16'h0028, 1'b1, 2, 3, 1'b0);
        do_scan(2, 16'h8000, 1'b1, 0, 2, 1'b0);
    endtask

    task automatic test_ignore_start();
        do_scan(2, 16'h8000, 1'b0, 15, 5, 1'b1);
        do_scan(2, 16'h0000, 1'b1, 16, 5, 1'b1);
    endtask

    task automatic test_mid_reset();
        cur = 0;
        drive(0, 1'b1, 16'h0080, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tot_cnt++;
            if (obs_done !== 1'b0 || obs_busy !== 1'b1)
                $display("FAIL pre_abort dut0 cyc%0d: busy=%b done=%b, required 1/0", c, obs_busy, obs_done);
            else pass_cnt++;
            if (c == 1) drive(0, 1'b0, 16'h0, 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_cnt !== 5'd0 || obs_az !== 1'b0)
            $display("FAIL abort dut0: busy=%b done=%b cnt=%0d az=%b, required all 0", obs_busy, obs_done, obs_cnt, obs_az);
        else pass_cnt++;
        $display("txn dut0 mid-scan reset busy=%b count=%0d", obs_busy, obs_cnt);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            prev_cnt[d] = 0;
            prev_az[d]  = 1'b0;
        end
        do_scan(0, 16'h0004, 1'b0, 2, 4, 1'b0);
    endtask

    task automatic test_hold();
        do_scan(0, 16'h0028, 1'b0, 3, 5, 1'b0);
        do_scan(0, 16'h0000, 1'b0, 8, 9, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] v, mask;
        bit          m;
        int          k;
        for (int d = 0; d < 3; d++) begin
            mask = 16'((32'd1 << W_TAB[d]) - 1);
            for (int n = 0; n < 14; n++) begin
                case ($urandom_range(3))
                    0:       v = 16'h0;
                    1:       v = 16'(32'd1 << $urandom_range(W_TAB[d] - 1));
                    2:       v = 16'($urandom);
                    default: v = 16'($urandom & $urandom & $urandom);
                endcase
                v = v & mask;
                m = 1'($urandom_range(1));
                k = ref_zeros(v, W_TAB[d], m);
                if ($urandom_range(1) == 1) @(negedge clk);
                do_scan(d, v, m, k, ref_done_cycle(k, W_TAB[d], S_TAB[d]), 1'($urandom_range(1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/zero_scan_counter.md
# zero_scan_counter

Parametrised, handshaked zero-run counter for the bit-scan utilities. On `start` it captures a WIDTH-bit word and counts trailing or leading zeros by scanning STEP bits per clock. The result is a registered count with an all-zero flag and a one-cycle `done` pulse. It is the multi-width, multi-mode successor of the team's 8-bit trailing-zero counter and feeds normalisation and priority logic downstream.

## Interface
- `WIDTH`, default 8: data width; must be ≥ 2.
- `STEP`, default 1: bits examined per SCAN cycle; must satisfy 1 ≤ STEP ≤ WIDTH and WIDTH % STEP == 0.
- `CW`, derived as $clog2(WIDTH+1): count width, so WIDTH itself is representable.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `data_in` in WIDTH: operand, captured on the accepted `start` edge.
- `mode` in 1: 0 counts trailing zeros (from bit 0 upward); 1 counts leading zeros (from bit WIDTH-1 downward). Captured with `data_in`.
- `busy` out 1: high in SCAN and DONE.
- `done` out 1: one-cycle pulse, high in DONE.
- `count_out` out CW: last result; valid from `done` and held until the next result.
- `all_zero` out 1: last operand was all zeros (count_out == WIDTH); held with `count_out`.

## Operation
- States:
  - IDLE → SCAN on `start`=1. Capture `data_in` into the shift register; bit-reverse it if `mode`=1, so the scan is always LSB-first. Clear the running count. Set chunk index = 0.
  - SCAN:
    - Evaluate the low STEP bits of the shift register.
    - If all of them are zero and this is not the last chunk: running count += STEP, shift the register right by STEP, increment the chunk index, stay in SCAN.
    - If any bit is one: result = running count + position of the lowest one within the chunk. Go to DONE with `all_zero`=0.
    - If this is the last chunk (index WIDTH/STEP−1) and it is all zero: result = WIDTH. Go to DONE with `all_zero`=1.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `count_out`/`all_zero` register only on the SCAN→DONE edge. While a scan is running they keep the previous result; the running count is never exposed.
- `start` in SCAN or DONE is ignored: no queueing and no restart. `data_in` and `mode` are don't-care outside the accepting edge.
- Arithmetic:
  - The running count is CW bits wide and never exceeds WIDTH, so no wrap is possible.
  - The within-chunk position is $clog2(STEP) bits, zero-extended before the add.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `count_out`=0, `all_zero`=0, shift register and running count = 0. Reset overrides `start` and aborts any scan in progress, with no `done` pulse.
- Let `start` be accepted at edge E0, and let k be the zero count of the operand.
- SCAN occupies cycles 1..S, where S = min(floor(k/STEP)+1, WIDTH/STEP).
- DONE (`done`=1, new `count_out` visible) is cycle S+1. IDLE is cycle S+2, and the earliest next accepted `start` is the edge ending cycle S+2.
- Worst case: S = WIDTH/STEP. Minimum latency, start edge to `done`, is 2 cycles (k < STEP).
- STEP = WIDTH gives a fixed 2-cycle latency.

## Structure
- Package `zero_scan_pkg`:
  - State enum {IDLE, SCAN, DONE}.
  - Function `cnt_width(w)` = $clog2(w+1).
  - Mode constants MODE_TRAIL=0 and MODE_LEAD=1.
- Sub-module `zero_chunk_enc` (combinational, parameter STEP):
  - Input: STEP-bit chunk.
  - Outputs: `any_one` and `pos`, the index of the lowest set bit, $clog2(STEP) bits wide; `pos`=0 when STEP=1.
- Top level holds the FSM, shift register, running count, bit-reversal and output registers.

## Test plan
- WIDTH=8, STEP=1, mode=0, data=8'b0010_1000 → `done` in cycle 5 after start edge, `count_out`=3, `all_zero`=0; `busy` high cycles 1–5.
- Same data, mode=1 → `done` cycle 4, `count_out`=2. Repeat with STEP=2: trailing → `count_out`=3, `done` cycle 3; leading → `count_out`=2, `done` cycle 3.
- WIDTH=8, STEP=1, data=0 → SCAN 8 cycles, `done` cycle 9, `count_out`=8, `all_zero`=1. Repeat with data=8'h01 → `count_out`=0, `done` cycle 2.
- WIDTH=16, STEP=4, data=16'h8000: mode 0 → `count_out`=15, `done` cycle 5; mode 1 → `count_out`=0, `done` cycle 2. A second `start` pulsed during SCAN is ignored, and the result is unchanged.
- Mid-scan reset: WIDTH=8, STEP=1, data=8'h80; drop `rst_n` in cycle 3 → next cycle IDLE, `busy`=0, `count_out`=0, no `done` pulse. A following start with data 8'h04 → `count_out`=2.
- Hold check: after a result of 3, start data 8'h00 → `count_out` stays 3 through SCAN, then becomes 8 exactly on the `done` cycle.
